// File: rtl/mod_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter_pkg
// Description : Shared constants for the modulo up/down counter and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : mod_counter_pkg
`default_nettype wire

// File: rtl/mod_counter_dff_ar_n.sv
`default_nettype none
// ============================================================================
// Module      : dff_ar_n
// Description : WIDTH-bit D register, asynchronous active-high reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_ar_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule : dff_ar_n
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_counter
// Description : Modulo-N up/down counter with load, clear, wrap or saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    generate
        if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
            $error("mod_counter: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_wrap_nxt;
    logic             w_at_max;
    logic             w_at_zero;

    assign w_at_max  = (r_q == c_max);
    assign w_at_zero = (r_q == '0);

    always_comb begin
        w_q_nxt    = r_q;
        w_wrap_nxt = 1'b0;
        if (clear) begin
            w_q_nxt = '0;
        end else if (load) begin
            // Out-of-range load data clamps to the top of the count range.
            w_q_nxt = (load_val > c_max) ? c_max : load_val;
        end else if (en) begin
            if (dir == DIR_UP) begin
                if (!w_at_max) begin
                    w_q_nxt = r_q + 1'b1;
                end else if (SATURATE == 0) begin
                    w_q_nxt    = '0;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                if (!w_at_zero) begin
                    w_q_nxt = r_q - 1'b1;
                end else if (SATURATE == 0) begin
                    w_q_nxt    = c_max;
                    w_wrap_nxt = 1'b1;
                end
            end
        end
    end

    dff_ar_n #(.WIDTH(WIDTH)) u_q_reg (
        .clk   (clk),
        .reset (reset),
        .d     (w_q_nxt),
        .q     (r_q)
    );

    // The wrap pulse shares the async reset, so a reset drops any pending pulse.
    dff_ar_n #(.WIDTH(1)) u_wrap_reg (
        .clk   (clk),
        .reset (reset),
        .d     (w_wrap_nxt),
        .q     (r_wrap)
    );

    assign tc   = en & ~clear & ~load & ((dir == DIR_DOWN) ? w_at_zero : w_at_max);
    assign q    = r_q;
    assign wrap = r_wrap;

endmodule : mod_counter
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_counter
// Description : Scoreboard bench: wrap (M=10), saturate (M=10), full range (M=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter;
    import mod_counter_pkg::*;

    typedef struct {
        int q [3];
        bit w [3];
    } exp_t;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       en;
    logic       dir;
    logic [3:0] qa, qb;
    logic [2:0] qc;
    logic       tca, tcb, tcc;
    logic       wa, wb, wc;

    int   n_checks = 0;
    int   n_errors = 0;
    int   stepno   = 0;
    int   mq [3];
    int   mm [3]   = '{10, 10, 8};
    bit   ms [3]   = '{1'b0, 1'b1, 1'b0};
    exp_t sb [$];

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dut_a (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .q(qa), .tc(tca), .wrap(wa));

    mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_dut_b (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .q(qb), .tc(tcb), .wrap(wb));

    mod_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_dut_c (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val[2:0]),
        .en(en), .dir(dir), .q(qc), .tc(tcc), .wrap(wc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", tag, stepno, got, exp);
        end
    endtask

    function automatic int dut_q(input int i);
        return (i == 0) ? int'(qa) : (i == 1) ? int'(qb) : int'(qc);
    endfunction

    function automatic int dut_tc(input int i);
        return (i == 0) ? int'(tca) : (i == 1) ? int'(tcb) : int'(tcc);
    endfunction

    function automatic int dut_w(input int i);
        return (i == 0) ? int'(wa) : (i == 1) ? int'(wb) : int'(wc);
    endfunction

    // Reference: modular arithmetic, a wrap is a step that crosses the range end.
    function automatic void model_next(input int q, input int m, input bit sat,
                                       input bit cl, input bit ld, input int lv,
                                       input bit e, input bit d,
                                       output int nq, output bit nw);
        int t;
        bit crossed;
        nq = q;
        nw = 1'b0;
        if (cl) begin
            nq = 0;
        end else if (ld) begin
            nq = (lv >= m) ? m - 1 : lv;
        end else if (e) begin
            t       = (d == DIR_DOWN) ? (q + m - 1) % m : (q + 1) % m;
            crossed = (d == DIR_DOWN) ? (t > q) : (t < q);
            if (!(crossed && sat)) begin
                nq = t;
                nw = crossed;
            end
        end
    endfunction

    task automatic step(input bit cl, input bit ld, input int lv, input bit e, input bit d);
        exp_t x;
        int   nq;
        bit   nw;
        bit   etc;
        @(negedge clk);
        stepno++;
        clear    = cl;
        load     = ld;
        load_val = lv[3:0];
        en       = e;
        dir      = d;
        #1;
        for (int i = 0; i < 3; i++) begin
            etc = e && !cl && !ld && ((d == DIR_DOWN) ? (mq[i] == 0) : (mq[i] == mm[i] - 1));
            chk($sformatf("tc%0d", i), dut_tc(i), int'(etc));
            model_next(mq[i], mm[i], ms[i], cl, ld, (i == 2) ? (lv & 7) : (lv & 15), e, d, nq, nw);
            x.q[i] = nq;
            x.w[i] = nw;
            mq[i]  = nq;
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("q%0d", i), dut_q(i), x.q[i]);
            chk($sformatf("wrap%0d", i), dut_w(i), int'(x.w[i]));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        stepno++;
        clear = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_q%0d", i), dut_q(i), 0);
            chk($sformatf("rst_wrap%0d", i), dut_w(i), 0);
            mq[i] = 0;
        end
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = '0;
        en       = 1'b0;
        dir      = DIR_UP;
        for (int i = 0; i < 3; i++) mq[i] = 0;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("por_q%0d", i), dut_q(i), 0);
            chk($sformatf("por_wrap%0d", i), dut_w(i), 0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Up count through the modulus boundary.
        for (int k = 0; k < 10; k++) step(0, 0, 0, 1, DIR_UP);
        chk("up_end_a", int'(qa), 0);
        chk("up_end_b", int'(qb), 9);

        // Down wrap from zero on the wrapping counter.
        step(0, 0, 0, 1, DIR_DOWN);
        chk("down_wrap_a", int'(qa), 9);

        // Load clamp beats enable, then clear beats load.
        step(0, 1, 12, 1, DIR_UP);
        chk("clamp_a", int'(qa), 9);
        chk("clamp_wrap_a", int'(wa), 0);
        step(1, 1, 3, 1, DIR_UP);
        chk("clear_a", int'(qa), 0);

        // Saturate at the top, then step down.
        step(0, 1, 9, 0, DIR_UP);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, DIR_UP);
        chk("sat_hold_b", int'(qb), 9);
        step(0, 0, 0, 1, DIR_DOWN);
        chk("sat_down_b", int'(qb), 8);

        // Direction changes while enabled.
        step(0, 0, 0, 1, DIR_UP);
        step(0, 0, 0, 1, DIR_DOWN);
        step(0, 0, 0, 1, DIR_UP);
        step(0, 0, 0, 1, DIR_UP);

        // Async reset mid-count, then resume from the first edge.
        step(0, 1, 5, 0, DIR_UP);
        pulse_reset();
        for (int k = 0; k < 3; k++) step(0, 0, 0, 1, DIR_UP);
        chk("resume_a", int'(qa), 3);

        // Full-range counter wraps both ways via natural overflow.
        step(0, 1, 7, 0, DIR_UP);
        step(0, 0, 0, 1, DIR_UP);
        chk("full_up_c", int'(qc), 0);
        chk("full_up_wrap_c", int'(wc), 1);
        step(0, 0, 0, 1, DIR_DOWN);
        chk("full_down_c", int'(qc), 7);

        // A reset during a pending wrap pulse drops it.
        step(0, 1, 7, 0, DIR_UP);
        step(0, 0, 0, 1, DIR_UP);
        pulse_reset();

        for (int k = 0; k < 60; k++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mod_counter
`default_nettype wire
